// File: rtl/alu_sequencer.sv
// alu_sequencer: debounced pushbutton front-end that sequences operand entry and captures the ULA results.
module alu_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_DIGIT       = 9,
    parameter int EXEC_CYCLES     = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [1:0] op,
    input  logic [7:0] result1,
    input  logic [7:0] result2,
    output logic [7:0] res1,
    output logic [7:0] res2,
    output logic       res_valid,
    output logic [2:0] state
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int EW = $clog2(EXEC_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [EW-1:0] E_LAST = EW'(EXEC_CYCLES - 1);
    localparam logic [7:0] MAXD = 8'(MAX_DIGIT);
    localparam logic [2:0] S_A = 3'd0, S_B = 3'd1, S_OP = 3'd2, S_EXEC = 3'd3, S_SHOW = 3'd4;
    logic [3:0] press;
    logic [EW-1:0] ecnt;
    logic clr, adv, inc, dec;
    for (genvar i = 0; i < 4; i++) begin : g_key
        logic s1, s2, deb, deb_d;
        logic [DW-1:0] cnt;
        always_ff @(posedge CLOCK_50 or posedge reset)
            if (reset) begin
                s1 <= 1'b1;
                s2 <= 1'b1;
                deb <= 1'b1;
                deb_d <= 1'b1;
                cnt <= '0;
            end else begin
                s1 <= KEY[i];
                s2 <= s1;
                deb_d <= deb;
                if (s2 == deb) cnt <= '0;
                else if (cnt == D_LAST) begin
                    deb <= s2;
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
            end
        assign press[i] = deb_d & ~deb;
    end
    // One event per cycle: clear > advance > increment > decrement; losers are dropped.
    assign clr = press[3];
    assign adv = press[0] & ~clr;
    assign inc = press[1] & ~press[0] & ~clr;
    assign dec = press[2] & ~press[1] & ~press[0] & ~clr;
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset || clr) begin
            a <= '0;
            b <= '0;
            op <= '0;
            res1 <= '0;
            res2 <= '0;
            res_valid <= 1'b0;
            state <= S_A;
            ecnt <= '0;
        end else
            case (state)
                S_A:
                    if (adv) state <= S_B;
                    else if (inc) a <= (a == MAXD) ? 8'd0 : a + 8'd1;
                    else if (dec) a <= (a == 8'd0) ? MAXD : a - 8'd1;
                S_B:
                    if (adv) state <= S_OP;
                    else if (inc) b <= (b == MAXD) ? 8'd0 : b + 8'd1;
                    else if (dec) b <= (b == 8'd0) ? MAXD : b - 8'd1;
                S_OP:
                    if (adv) begin
                        state <= S_EXEC;
                        ecnt <= '0;
                    end else if (inc) op <= op + 2'd1;
                    else if (dec) op <= op - 2'd1;
                S_EXEC:
                    if (ecnt == E_LAST) begin
                        res1 <= result1;
                        res2 <= result2;
                        res_valid <= 1'b1;
                        state <= S_SHOW;
                    end else ecnt <= ecnt + 1'b1;
                S_SHOW:
                    if (adv) begin
                        state <= S_A;
                        res_valid <= 1'b0;
                    end
                default: state <= S_A;
            endcase
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a small ULA model.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] KEY = 4'hF;
    logic [7:0] a, b, result1, result2, res1, res2;
    logic [1:0] op;
    logic       res_valid;
    logic [2:0] state;
    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [7:0] a, b;
        logic [1:0] op;
        logic [2:0] st;
        logic       rv;
        logic [7:0] r1, r2;
    } exp_t;
    typedef struct {
        logic [7:0] r1, r2;
    } res_t;
    exp_t exp_q[$];
    res_t res_q[$];
    event chk_ev;

    alu_sequencer #(.DEBOUNCE_CYCLES(4), .MAX_DIGIT(9), .EXEC_CYCLES(2)) dut (
        .CLOCK_50(clk), .reset(reset), .KEY(KEY), .a(a), .b(b), .op(op),
        .result1(result1), .result2(result2), .res1(res1), .res2(res2),
        .res_valid(res_valid), .state(state)
    );

    always #5 clk = ~clk;

    // ULA model: op selects add/sub/and/or on result1, result2 is the product.
    always_comb begin
        result1 = (op == 2'd0) ? a + b : (op == 2'd1) ? a - b : (op == 2'd2) ? (a & b) : (a | b);
        result2 = 8'(a * b);
    end

    always begin
        @(negedge clk or chk_ev);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({a, b, op, state, res_valid, res1, res2} !== {e.a, e.b, e.op, e.st, e.rv, e.r1, e.r2}) begin
                failures++;
                $display("FAIL %s: got a=%0d b=%0d op=%0d state=%0d rv=%0b res1=%h res2=%h, want a=%0d b=%0d op=%0d state=%0d rv=%0b res1=%h res2=%h",
                         e.name, a, b, op, state, res_valid, res1, res2, e.a, e.b, e.op, e.st, e.rv, e.r1, e.r2);
            end
        end
    end

    always @(posedge res_valid) begin
        #1;
        checks++;
        if (res_q.size() == 0) begin
            failures++;
            $display("FAIL capture: unexpected res_valid with res1=%h res2=%h", res1, res2);
        end else begin
            res_t r;
            r = res_q.pop_front();
            if ({res1, res2} !== {r.r1, r.r2}) begin
                failures++;
                $display("FAIL capture: got res1=%h res2=%h, want res1=%h res2=%h", res1, res2, r.r1, r.r2);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string name, input logic [7:0] ea, eb, input logic [1:0] eop,
                             input logic [2:0] est, input logic erv, input logic [7:0] er1, er2);
        exp_t e;
        e.name = name; e.a = ea; e.b = eb; e.op = eop; e.st = est; e.rv = erv; e.r1 = er1; e.r2 = er2;
        exp_q.push_back(e);
    endtask

    task automatic press_keys(input logic [3:0] mask);
        KEY = ~mask;
        tick(12);
        KEY = 4'hF;
        tick(12);
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(1);
        expect_st("reset", 0, 0, 0, 0, 0, 0, 0);
        // Latency: register update exactly 7 edges after the raw fall, one event while held.
        KEY = 4'b1101;
        tick(6);
        expect_st("latency_before", 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        expect_st("latency_at", 1, 0, 0, 0, 0, 0, 0);
        tick(13);
        expect_st("held_once", 1, 0, 0, 0, 0, 0, 0);
        KEY = 4'hF;
        tick(12);
        expect_st("release_no_event", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            KEY[1] = ~KEY[1];
            tick(2);
        end
        KEY = 4'hF;
        tick(12);
        expect_st("bounce", 1, 0, 0, 0, 0, 0, 0);
        press_keys(4'b0010);
        expect_st("after_bounce_press", 2, 0, 0, 0, 0, 0, 0);
        press_keys(4'b1000);
        expect_st("clear", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) press_keys(4'b0010);
        expect_st("inc_to_max", 9, 0, 0, 0, 0, 0, 0);
        press_keys(4'b0010);
        expect_st("wrap_up", 0, 0, 0, 0, 0, 0, 0);
        press_keys(4'b0100);
        expect_st("wrap_down", 9, 0, 0, 0, 0, 0, 0);
        press_keys(4'b0001);
        press_keys(4'b0100);
        expect_st("b_wrap_down", 9, 9, 0, 1, 0, 0, 0);
        press_keys(4'b0001);
        press_keys(4'b0100);
        expect_st("op_wrap_down", 9, 9, 3, 2, 0, 0, 0);
        press_keys(4'b1000);
        // Full sequence a=3, b=5, op=1: 3-5 = 0xFE, 3*5 = 0x0F.
        for (int i = 0; i < 3; i++) press_keys(4'b0010);
        press_keys(4'b0001);
        for (int i = 0; i < 5; i++) press_keys(4'b0010);
        press_keys(4'b0001);
        press_keys(4'b0010);
        expect_st("op_entry", 3, 5, 1, 2, 0, 0, 0);
        res_q.push_back('{8'hFE, 8'h0F});
        KEY = 4'b1110;
        tick(7);
        expect_st("exec_1", 3, 5, 1, 3, 0, 0, 0);
        tick(1);
        expect_st("exec_2", 3, 5, 1, 3, 0, 0, 0);
        tick(1);
        expect_st("show", 3, 5, 1, 4, 1, 8'hFE, 8'h0F);
        KEY = 4'hF;
        tick(12);
        press_keys(4'b0010);
        expect_st("show_inc_ignored", 3, 5, 1, 4, 1, 8'hFE, 8'h0F);
        press_keys(4'b0001);
        expect_st("show_advance", 3, 5, 1, 0, 0, 8'hFE, 8'h0F);
        press_keys(4'b0011);
        expect_st("adv_beats_inc", 3, 5, 1, 1, 0, 8'hFE, 8'h0F);
        press_keys(4'b1001);
        expect_st("clear_beats_adv", 0, 0, 0, 0, 0, 0, 0);
        // Asynchronous reset mid-EXEC, between edges.
        press_keys(4'b0001);
        press_keys(4'b0001);
        KEY = 4'b1110;
        tick(7);
        expect_st("exec_before_reset", 0, 0, 0, 3, 0, 0, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        KEY = 4'hF;
        #1;
        expect_st("async_reset", 0, 0, 0, 0, 0, 0, 0);
        ->chk_ev;
        tick(2);
        reset = 1'b0;
        tick(12);
        expect_st("after_reset", 0, 0, 0, 0, 0, 0, 0);
        press_keys(4'b0010);
        expect_st("first_press_after_reset", 1, 0, 0, 0, 0, 0, 0);
        tick(2);
        checks++;
        if (res_q.size() != 0) begin
            failures++;
            $display("FAIL capture_pending: got %0d outstanding captures, want 0", res_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Front-end controller for the 8-bit ULA and its seven-segment displays. It synchronises and debounces the four active-low pushbuttons and runs an operand-entry state machine (edit A, edit B, edit op, execute, show). It drives the ULA a/b/op inputs from registers and captures the ULA results into held output registers with a valid flag. It replaces the per-button posedge-KEY counters with a single clocked, reset-able design on CLOCK_50.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button level change (20 ms at 50 MHz).
- MAX_DIGIT, 9: largest value of operands a and b; they wrap MAX_DIGIT<->0.
- EXEC_CYCLES, 2: cycles spent in EXEC before capturing the ULA outputs (settle time); minimum 1.

Ports:
- CLOCK_50  in   1  system clock; all state is on its rising edge.
- reset     in   1  asynchronous, active-high reset.
- KEY       in   4  raw pushbuttons, active-low. KEY[0]=advance, KEY[1]=increment, KEY[2]=decrement, KEY[3]=clear.
- a         out  8  operand A to the ULA and display.
- b         out  8  operand B to the ULA and display.
- op        out  2  ULA operation select.
- result1   in   8  ULA result1 (combinational from a/b/op).
- result2   in   8  ULA result2.
- res1      out  8  captured result1.
- res2      out  8  captured result2.
- res_valid out  1  res1/res2 hold a capture for the current a/b/op.
- state     out  3  FSM code for LEDs: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.

Behaviour:
- Reset (asynchronous, any time, including mid-EXEC):
  - a=b=op=0, res1=res2=0, res_valid=0, state=S_A.
  - Debounced levels = 1 (released); debounce counters = 0; exec counter = 0.
- Input conditioning, per key:
  - 2-FF synchroniser.
  - Debounce: the counter increments each cycle the synced level differs from the debounced level, and clears when they match. When it reaches DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES produces no event.
  - Press event = one-cycle pulse on the debounced 1->0 transition. Release produces no event. Holding a key gives exactly one event.
  - Latency from a clean raw falling edge to the register update is DEBOUNCE_CYCLES+3 cycles.
- Event arbitration: at most one event is acted on per cycle, in priority KEY[3] > KEY[0] > KEY[1] > KEY[2]. Lower-priority simultaneous events are dropped, not queued.
- Clear event (any state): a=b=op=0, res_valid=0, res1=res2=0, state goes to S_A.
- S_A:
  - increment: a = (a==MAX_DIGIT) ? 0 : a+1.
  - decrement: a = (a==0) ? MAX_DIGIT : a-1.
  - advance: go to S_B.
- S_B: same increment/decrement rules applied to b; advance goes to S_OP.
- S_OP:
  - increment/decrement: op is a 2-bit modular counter (3->0, 0->3).
  - advance: go to S_EXEC and load the exec counter with 0.
- S_EXEC:
  - Increment, decrement and advance are ignored; a/b/op are frozen.
  - The counter increments each cycle. In the cycle it equals EXEC_CYCLES-1, res1/res2 capture result1/result2, res_valid goes to 1 on the next edge, and state goes to S_SHOW.
  - Clear preempts the capture.
- S_SHOW:
  - Increment and decrement are ignored.
  - advance: go to S_A and set res_valid=0; a/b/op are retained and res1/res2 are held.
- Any modification of a/b/op through clear or state change never occurs while res_valid=1. res_valid=1 therefore guarantees the results match the displayed a/b/op.
- Operands never exceed MAX_DIGIT; the upper bits of a/b stay 0.

Test Plan:
All cases use DEBOUNCE_CYCLES=4, EXEC_CYCLES=2, and a ULA model in the bench.
1. Reset -> a=0, b=0, op=0, state=0, res_valid=0. Press KEY[1] clean, held 20 cycles -> a=1 exactly 7 cycles after the raw fall, with one increment only.
2. Bounce: KEY[1] toggled low/high every 2 cycles for 12 cycles, then released -> a unchanged. Then a clean press -> a+1.
3. Wrap: in S_A, press KEY[1] 10 times -> a=0. Press KEY[2] once -> a=9. In S_OP with op=0, press decrement -> op=3.
4. Full sequence: a=3 (S_A), advance, b=5, advance, op=1, advance -> state=3 for 2 cycles, then state=4. res1/res2 equal the ULA outputs for (3,5,1) and res_valid=1. Increment in S_SHOW -> no change. Advance -> state=0, res_valid=0, a=3 retained.
5. Simultaneous: KEY[0] and KEY[1] pressed in the same cycle in S_A -> state=1, a unchanged. KEY[3] with KEY[0] -> state=0, all registers 0.
6. Reset asserted asynchronously in S_EXEC, between clock edges -> outputs go to reset values immediately. After release, the first clean press is processed normally.
